// File: rtl/data_mem_lsu.sv
// data_mem_lsu: byte-addressed data memory for the MEM stage.
// Serves one load/store port with RV32I byte/half/word accesses, sign/zero
// extension on loads and misalignment/illegal-code detection. Load responses
// are registered with RD_LATENCY (1 or 2) cycles of latency. When
// CLEAR_ON_RESET=1 a sequencer zeroes every word after reset before the port
// accepts requests.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-low reset
//   req     access request (accepted when ready=1)
//   we      1 = store, 0 = load
//   funct3  RV32I size/sign code
//   A       byte address (wraps modulo DEPTH_WORDS*4)
//   WD      store data, low bits used for sub-word stores
//   ready   port can accept a request this cycle
//   rvalid  one-cycle load response strobe
//   RD      extended load data, held between responses
//   err     one-cycle strobe for misaligned or illegal accesses
module data_mem_lsu #(
  parameter int unsigned DEPTH_WORDS    = 1024,
  parameter int unsigned RD_LATENCY     = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter string       INIT_FILE      = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] RD,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  logic [31:0]   r_mem [DEPTH_WORDS];

  state_e        r_state, w_state_d;
  logic [AW-1:0] r_clr_cnt, w_clr_cnt_d;
  logic          w_clr_we;
  logic          r_ready;

  logic [AW-1:0] w_idx;
  logic          w_acc, w_ld_acc;
  logic          w_misal, w_illegal, w_bad;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_word, w_ld_data;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;

  logic          r_v1, r_e1;
  logic [31:0]   r_d1;
  logic          w_pv, w_pe;
  logic [31:0]   w_pd;
  logic          r_rvalid, r_err;
  logic [31:0]   r_rd;

  // Address bits above the array are ignored (address wrap).
  logic          w_unused_addr;
  assign w_unused_addr = ^A[31:AW+2];

  // ---------------------------------------------------------------------------
  // Clear / run FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_d   = r_state;
    w_clr_cnt_d = r_clr_cnt;
    w_clr_we    = 1'b0;
    unique case (r_state)
      StInit: begin
        if (CLEAR_ON_RESET) begin
          w_clr_we    = 1'b1;
          w_clr_cnt_d = r_clr_cnt + 1'b1;
          if (r_clr_cnt == AW'(DEPTH_WORDS - 1)) begin
            w_state_d   = StRun;
            w_clr_cnt_d = '0;
          end
        end else begin
          w_state_d = StRun;
        end
      end
      StRun:   w_state_d = StRun;
      default: w_state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= CLEAR_ON_RESET ? StInit : StRun;
      r_clr_cnt <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_clr_cnt <= w_clr_cnt_d;
      // Registered so ready stays low in reset and for the first edge after it.
      r_ready   <= (w_state_d == StRun);
    end
  end

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign w_idx    = A[AW+1:2];
  assign w_acc    = req & r_ready;
  assign w_ld_acc = w_acc & ~we;

  assign w_misal = ((funct3[1:0] == 2'b01) & A[0]) |
                   ((funct3[1:0] == 2'b10) & (A[1:0] != 2'b00));

  always_comb begin
    w_illegal = 1'b1;
    if (we) begin
      case (funct3)
        3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
        default:                w_illegal = 1'b1;
      endcase
    end else begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_illegal = 1'b0;
        default:                                w_illegal = 1'b1;
      endcase
    end
  end

  assign w_bad = w_misal | w_illegal;

  // Store lane enables with data replicated onto every lane.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = '0;
    if (w_acc && we && !w_bad) begin
      case (funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << A[1:0];
          w_wdata = {4{WD[7:0]}};
        end
        2'b01: begin
          w_be    = A[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{WD[15:0]}};
        end
        2'b10: begin
          w_be    = 4'b1111;
          w_wdata = WD;
        end
        default: w_be = 4'b0000;
      endcase
    end
  end

  // Array has no reset: contents survive reset unless the clear sequencer runs.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_cnt] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load extraction; the word is sampled at the acceptance edge
  // ---------------------------------------------------------------------------
  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[{A[1:0], 3'b000} +: 8];
  assign w_half = A[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_ld_data = '0;
    if (!w_bad) begin
      case (funct3)
        3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
        3'b100:  w_ld_data = {24'h0, w_byte};
        3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
        3'b101:  w_ld_data = {16'h0, w_half};
        3'b010:  w_ld_data = w_word;
        default: w_ld_data = '0;
      endcase
    end
  end

  // Stage 1 is only on the response path when RD_LATENCY == 2.
  assign w_pv = (RD_LATENCY == 2) ? r_v1 : w_ld_acc;
  assign w_pd = (RD_LATENCY == 2) ? r_d1 : w_ld_data;
  assign w_pe = (RD_LATENCY == 2) ? r_e1 : (w_ld_acc & w_bad);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1     <= 1'b0;
      r_d1     <= '0;
      r_e1     <= 1'b0;
      r_rvalid <= 1'b0;
      r_rd     <= '0;
      r_err    <= 1'b0;
    end else begin
      r_v1     <= w_ld_acc;
      r_d1     <= w_ld_data;
      r_e1     <= w_ld_acc & w_bad;
      r_rvalid <= w_pv;
      if (w_pv) r_rd <= w_pd;
      // Store errors report right away; load errors ride with rvalid.
      r_err    <= (w_acc & we & w_bad) | w_pe;
    end
  end

  assign ready  = r_ready;
  assign rvalid = r_rvalid;
  assign RD     = r_rd;
  assign err    = r_err;

endmodule

// File: tb/tb_data_mem_lsu.sv
module tb_data_mem_lsu;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] A;
  logic [31:0] WD;

  logic        ready1, rvalid1, err1;
  logic [31:0] rd1;
  logic        ready2, rvalid2, err2;
  logic [31:0] rd2;
  logic        ready3, rvalid3, err3;
  logic [31:0] rd3;

  int errors = 0;
  int checks = 0;

  // Per-access captures: "n1" is one cycle after acceptance, "n2" two cycles.
  logic        c1_v, c1_err, c2_v_n1, c2_err_n1, c1_v_n2, c2_v, c2_err, c3_v;
  logic [31:0] c1_rd, c2_rd, c3_rd;

  // Per-cycle captures for multi-cycle sequences.
  logic        s_v1 [8];
  logic        s_v2 [8];
  logic [31:0] s_rd1 [8];
  logic [31:0] s_rd2 [8];
  int          s_idx;

  // Lat 1, clear on reset.
  data_mem_lsu #(.DEPTH_WORDS(16), .RD_LATENCY(1), .CLEAR_ON_RESET(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .A(A), .WD(WD),
    .ready(ready1), .rvalid(rvalid1), .RD(rd1), .err(err1)
  );
  // Lat 2, clear on reset.
  data_mem_lsu #(.DEPTH_WORDS(16), .RD_LATENCY(2), .CLEAR_ON_RESET(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .A(A), .WD(WD),
    .ready(ready2), .rvalid(rvalid2), .RD(rd2), .err(err2)
  );
  // Lat 1, contents kept across reset.
  data_mem_lsu #(.DEPTH_WORDS(16), .RD_LATENCY(1), .CLEAR_ON_RESET(1'b0)) u_dut3 (
    .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .A(A), .WD(WD),
    .ready(ready3), .rvalid(rvalid3), .RD(rd3), .err(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One request driven at a negedge; returns at the second negedge after it.
  task automatic access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d);
    req = 1'b1; we = w; funct3 = f3; A = a; WD = d;
    @(negedge clk);
    req = 1'b0;
    c1_v = rvalid1; c1_rd = rd1; c1_err = err1;
    c2_v_n1 = rvalid2; c2_err_n1 = err2;
    c3_v = rvalid3; c3_rd = rd3;
    @(negedge clk);
    c2_v = rvalid2; c2_rd = rd2; c2_err = err2; c1_v_n2 = rvalid1;
  endtask

  // One cycle of word-sized traffic (or idle), sampled at the next negedge.
  task automatic step(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d);
    req = r; we = w; funct3 = 3'b010; A = a; WD = d;
    @(negedge clk);
    s_v1[s_idx] = rvalid1; s_rd1[s_idx] = rd1;
    s_v2[s_idx] = rvalid2; s_rd2[s_idx] = rd2;
    s_idx++;
  endtask

  // Bounded wait for ready; 0 means never seen within the budget.
  task automatic wait_clear(output int n1, output int n2, output int n3);
    n1 = 0; n2 = 0; n3 = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (ready1 && n1 == 0) n1 = c;
      if (ready2 && n2 == 0) n2 = c;
      if (ready3 && n3 == 0) n3 = c;
    end
  endtask

  task automatic test_reset;
    int n1, n2, n3;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ready1, rvalid1, err1, ready2, rvalid2, err2, ready3, rvalid3, err3} !== 9'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0",
               {ready1, rvalid1, err1, ready2, rvalid2, err2, ready3, rvalid3, err3});
    end
    checks++;
    if ((rd1 | rd2 | rd3) !== 32'h0) begin
      errors++;
      $display("FAIL reset_rd: got %h/%h/%h expected 0", rd1, rd2, rd3);
    end
    rst = 1'b1;
    wait_clear(n1, n2, n3);
    checks++;
    if (n1 != 16 || n2 != 16 || n3 != 1) begin
      errors++;
      $display("FAIL first_clear_time: got %0d/%0d/%0d expected 16/16/1", n1, n2, n3);
    end
    for (int i = 0; i < 16; i++) access(1'b1, 3'b010, 32'(i * 4), 32'hFFFF_FFFF);
    access(1'b0, 3'b010, 32'h14, 32'h0);
    checks++;
    if (c1_rd !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL fill_readback: got %h expected ffffffff", c1_rd);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ready1, rvalid1, err1, ready3} !== 4'b0 || rd1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_again: got ready=%b rd=%h expected 0", ready1, rd1);
    end
    rst = 1'b1;
    wait_clear(n1, n2, n3);
    checks++;
    if (n1 != 16 || n2 != 16 || n3 != 1) begin
      errors++;
      $display("FAIL clear_time: got %0d/%0d/%0d expected 16/16/1", n1, n2, n3);
    end
    for (int i = 0; i < 16; i++) begin
      access(1'b0, 3'b010, 32'(i * 4), 32'h0);
      checks++;
      if (c1_v !== 1'b1 || c1_rd !== 32'h0 || c2_rd !== 32'h0) begin
        errors++;
        $display("FAIL cleared_word%0d: got %b %h %h expected 1 0 0", i, c1_v, c1_rd, c2_rd);
      end
      if (i == 5) begin
        checks++;
        if (c3_rd !== 32'hFFFF_FFFF) begin
          errors++;
          $display("FAIL no_clear_keep: got %h expected ffffffff", c3_rd);
        end
      end
    end
  endtask

  task automatic test_subword;
    access(1'b1, 3'b010, 32'h20, 32'h1122_3344);
    access(1'b1, 3'b000, 32'h21, 32'h0000_00AA);
    access(1'b1, 3'b001, 32'h22, 32'h0000_BEEF);
    access(1'b0, 3'b010, 32'h20, 32'h0);
    checks++;
    if (c1_rd !== 32'hBEEF_AA44 || c2_rd !== 32'hBEEF_AA44) begin
      errors++;
      $display("FAIL subword: got %h/%h expected beefaa44", c1_rd, c2_rd);
    end
  endtask

  task automatic test_extension;
    logic [2:0]  f3s  [5];
    logic [31:0] adrs [5];
    logic [31:0] exps [5];
    f3s  = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101};
    adrs = '{32'h40, 32'h43, 32'h43, 32'h42, 32'h42};
    exps = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80F0, 32'h0000_80F0};
    access(1'b1, 3'b010, 32'h40, 32'h80F0_017F);
    for (int i = 0; i < 5; i++) begin
      access(1'b0, f3s[i], adrs[i], 32'h0);
      checks++;
      if (c1_rd !== exps[i] || c2_rd !== exps[i] || c1_err !== 1'b0) begin
        errors++;
        $display("FAIL ext%0d: got %h/%h err=%b expected %h", i, c1_rd, c2_rd, c1_err, exps[i]);
      end
    end
  endtask

  task automatic test_misalign;
    access(1'b1, 3'b010, 32'h30, 32'hCAFE_F00D);
    checks++;
    if (c1_err !== 1'b0) begin
      errors++;
      $display("FAIL good_store_err: got %b expected 0", c1_err);
    end
    access(1'b1, 3'b010, 32'h31, 32'h1234_5678);
    checks++;
    if (c1_err !== 1'b1 || c2_err_n1 !== 1'b1 || c1_v !== 1'b0) begin
      errors++;
      $display("FAIL misal_store_err: got %b/%b v=%b expected 1/1 v=0", c1_err, c2_err_n1, c1_v);
    end
    checks++;
    if (c1_v_n2 !== 1'b0 || c2_err !== 1'b0) begin
      errors++;
      $display("FAIL store_err_pulse: got v=%b err2=%b expected 0 0", c1_v_n2, c2_err);
    end
    access(1'b0, 3'b010, 32'h30, 32'h0);
    checks++;
    if (c1_rd !== 32'hCAFE_F00D || c2_rd !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL misal_no_write: got %h/%h expected cafef00d", c1_rd, c2_rd);
    end
    access(1'b0, 3'b001, 32'h33, 32'h0);
    checks++;
    if (c1_v !== 1'b1 || c1_rd !== 32'h0 || c1_err !== 1'b1) begin
      errors++;
      $display("FAIL misal_lh_lat1: got v=%b rd=%h err=%b expected 1 0 1", c1_v, c1_rd, c1_err);
    end
    checks++;
    if (c2_v !== 1'b1 || c2_rd !== 32'h0 || c2_err !== 1'b1 || c2_err_n1 !== 1'b0) begin
      errors++;
      $display("FAIL misal_lh_lat2: got v=%b rd=%h err=%b early=%b expected 1 0 1 0",
               c2_v, c2_rd, c2_err, c2_err_n1);
    end
    access(1'b0, 3'b011, 32'h30, 32'h0);
    checks++;
    if (c1_err !== 1'b1 || c1_v !== 1'b1 || c1_rd !== 32'h0) begin
      errors++;
      $display("FAIL illegal_load: got err=%b v=%b rd=%h expected 1 1 0", c1_err, c1_v, c1_rd);
    end
    access(1'b1, 3'b100, 32'h30, 32'h0);
    access(1'b0, 3'b010, 32'h30, 32'h0);
    checks++;
    if (c1_rd !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL illegal_store_no_write: got %h expected cafef00d", c1_rd);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) access(1'b1, 3'b010, 32'(i * 4), 32'(i + 1));
    s_idx = 0;
    for (int i = 0; i < 7; i++) step(i < 4, 1'b0, 32'(i * 4), 32'h0);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (s_v1[i] !== (i < 4) || (i < 4 && s_rd1[i] !== 32'(i + 1))) begin
        errors++;
        $display("FAIL b2b_lat1_cyc%0d: got v=%b rd=%h", i + 1, s_v1[i], s_rd1[i]);
      end
      checks++;
      if (s_v2[i] !== (i >= 1 && i <= 4) || (i >= 1 && i <= 4 && s_rd2[i] !== 32'(i))) begin
        errors++;
        $display("FAIL b2b_lat2_cyc%0d: got v=%b rd=%h", i + 1, s_v2[i], s_rd2[i]);
      end
    end
    checks++;
    if (s_rd1[6] !== 32'h4 || s_rd2[6] !== 32'h4) begin
      errors++;
      $display("FAIL rd_hold: got %h/%h expected 4", s_rd1[6], s_rd2[6]);
    end
    // Store then load to the same word on the next cycle.
    s_idx = 0;
    step(1'b1, 1'b1, 32'h8, 32'h55);
    step(1'b1, 1'b0, 32'h8, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (s_v1[1] !== 1'b1 || s_rd1[1] !== 32'h55 || s_v2[2] !== 1'b1 || s_rd2[2] !== 32'h55) begin
      errors++;
      $display("FAIL raw: got %b %h / %b %h expected 1 55", s_v1[1], s_rd1[1], s_v2[2], s_rd2[2]);
    end
    // Store lands while an older load to the same word is still in flight.
    s_idx = 0;
    step(1'b1, 1'b0, 32'hC, 32'h0);
    step(1'b1, 1'b1, 32'hC, 32'h99);
    step(1'b1, 1'b0, 32'hC, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (s_v2[1] !== 1'b1 || s_rd2[1] !== 32'h4 || s_v2[2] !== 1'b0) begin
      errors++;
      $display("FAIL inflight_old: got v=%b rd=%h next_v=%b expected 1 4 0",
               s_v2[1], s_rd2[1], s_v2[2]);
    end
    checks++;
    if (s_v2[3] !== 1'b1 || s_rd2[3] !== 32'h99 || s_rd1[2] !== 32'h99 || s_rd1[0] !== 32'h4) begin
      errors++;
      $display("FAIL inflight_new: got %h %h %h expected 99 99 4", s_rd2[3], s_rd1[2], s_rd1[0]);
    end
  endtask

  task automatic test_reset_mid_load;
    int  n1, n2, n3;
    logic seen;
    s_idx = 0;
    step(1'b1, 1'b0, 32'h4, 32'h0);
    req = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (s_v1[0] !== 1'b1 || rvalid1 !== 1'b0 || rd1 !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_clear: got pre=%b v=%b rd=%h expected 1 0 0", s_v1[0], rvalid1, rd1);
    end
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen = seen | rvalid2;
    end
    rst = 1'b1;
    n1 = 0; n2 = 0; n3 = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      seen = seen | rvalid2;
      if (ready1 && n1 == 0) n1 = c;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL lost_response: got rvalid seen=%b expected 0", seen);
    end
    checks++;
    if (n1 != 16) begin
      errors++;
      $display("FAIL reclear_time: got %0d expected 16", n1);
    end
    access(1'b1, 3'b010, 32'h40, 32'hA5A5_5A5A);
    access(1'b0, 3'b010, 32'h0, 32'h0);
    checks++;
    if (c1_rd !== 32'hA5A5_5A5A || c2_rd !== 32'hA5A5_5A5A) begin
      errors++;
      $display("FAIL wrap: got %h/%h expected a5a55a5a", c1_rd, c2_rd);
    end
    access(1'b0, 3'b010, 32'h4, 32'h0);
    checks++;
    if (c1_rd !== 32'h0) begin
      errors++;
      $display("FAIL wrap_other_word: got %h expected 0", c1_rd);
    end
  endtask

  initial begin
    rst = 1'b0; req = 1'b0; we = 1'b0; funct3 = 3'b000; A = '0; WD = '0;
    @(negedge clk);
    test_reset;
    test_subword;
    test_extension;
    test_misalign;
    test_back_to_back;
    test_reset_mid_load;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
